unit_controller: RTL and testbench

- Sequencer that drives the 16-bit unit enable bus. Each enable pair is a one-hot output-enable (oen) on the source unit and a one-hot input-enable (ien) on the destination unit.
- Runs a fetch / decode / execute loop for a move-style ISA. Each instruction is one transfer: destination unit index and source unit index.
- Sits between the skin (external memory/port interface) and the common register file. Observes IR and issues the oen/ien pulses that move data.
- Owns the skin request/acknowledge handshake for every skin-side transfer.

---
 rtl/unit_controller.sv | 154 +++++++++++++++
 tb/tb_unit_controller.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_controller.sv
// Fetch/decode/execute sequencer for the move-style ISA: drives one-hot unit
// enables and owns the skin request/acknowledge handshake with ack timeout.
module unit_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_skin_ack,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  output logic                  o_skin_req,
  output logic [1:0]            o_skin_sel,
  output logic                  o_skin_we,
  output logic [15:0]           o_unit_ien,
  output logic [15:0]           o_unit_oen,
  output logic                  o_busy,
  output logic                  o_halted,
  output logic                  o_timeout
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, FETCH_REQ, FETCH_LOAD, DECODE, NOP, MOVE,
    SKIN_RD, RD_LOAD, SKIN_WR, WR_DONE, HALT
  } state_t;

  state_t        state, state_n;
  logic [3:0]    src_q, dst_q, src_n, dst_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ack_expired;
  logic          src_skin, dst_skin, src_rsvd, dst_rsvd;
  logic          req_n, we_n, busy_n, halted_n, timeout_n;
  logic [1:0]    sel_n;
  logic [15:0]   ien_n, oen_n;
  logic          unused_ir;

  // Fields come straight from IR while decoding so the first execute cycle's
  // registered enables are already correct; later states use the latched copy.
  assign src_n    = (state == DECODE) ? i_instruction[3:0] : src_q;
  assign dst_n    = (state == DECODE) ? i_instruction[7:4] : dst_q;
  assign src_skin = (src_n >= 4'd11) && (src_n <= 4'd13);
  assign dst_skin = (dst_n >= 4'd11) && (dst_n <= 4'd13);
  assign src_rsvd = (src_n >= 4'd14);
  assign dst_rsvd = (dst_n >= 4'd14);
  assign unused_ir = ^i_instruction;

  assign ack_expired = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    timeout_n = o_timeout;
    req_n     = 1'b0;
    sel_n     = '0;
    we_n      = 1'b0;
    ien_n     = '0;
    oen_n     = '0;
    halted_n  = 1'b0;

    case (state)
      IDLE, HALT: begin
        if (i_start) begin
          state_n   = FETCH_REQ;
          timeout_n = 1'b0;
        end
      end
      FETCH_REQ, SKIN_RD, SKIN_WR: begin
        if (i_skin_ack) begin
          case (state)
            FETCH_REQ: state_n = FETCH_LOAD;
            SKIN_RD:   state_n = RD_LOAD;
            default:   state_n = WR_DONE;
          endcase
        end else if (ack_expired) begin
          state_n   = HALT;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FETCH_LOAD: state_n = DECODE;
      DECODE: begin
        if (src_n == 4'd15 && dst_n == 4'd15) state_n = HALT;
        else if (src_rsvd || dst_rsvd)        state_n = NOP;
        else if (src_skin && dst_skin)        state_n = NOP;
        else if (src_skin)                    state_n = SKIN_RD;
        else if (dst_skin)                    state_n = SKIN_WR;
        else                                  state_n = MOVE;
      end
      NOP, MOVE, RD_LOAD, WR_DONE: state_n = FETCH_REQ;
      default: state_n = IDLE;
    endcase

    case (state_n)
      FETCH_REQ: req_n = 1'b1;
      FETCH_LOAD: begin
        oen_n = 16'h0800;
        ien_n = 16'h0001;
      end
      MOVE, RD_LOAD: begin
        oen_n = 16'h0001 << src_n;
        ien_n = 16'h0001 << dst_n;
      end
      SKIN_RD: begin
        req_n = 1'b1;
        sel_n = 2'(src_n - 4'd11);
      end
      SKIN_WR: begin
        req_n = 1'b1;
        we_n  = 1'b1;
        sel_n = 2'(dst_n - 4'd11);
        oen_n = 16'h0001 << src_n;
      end
      HALT: halted_n = 1'b1;
      default: ;
    endcase

    busy_n = !(state_n inside {IDLE, HALT});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt        <= '0;
      o_skin_req <= 1'b0;
      o_skin_sel <= '0;
      o_skin_we  <= 1'b0;
      o_unit_ien <= '0;
      o_unit_oen <= '0;
      o_busy     <= 1'b0;
      o_halted   <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      dst_q      <= dst_n;
      cnt        <= cnt_n;
      o_skin_req <= req_n;
      o_skin_sel <= sel_n;
      o_skin_we  <= we_n;
      o_unit_ien <= ien_n;
      o_unit_oen <= oen_n;
      o_busy     <= busy_n;
      o_halted   <= halted_n;
      o_timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_unit_controller.sv
// Bench for unit_controller: a per-instruction expectation generator builds the
// cycle-by-cycle output trace and ack/start stimulus; each task replays and compares.
module tb_unit_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_skin_ack;
  logic [15:0] i_instruction;
  logic        o_skin_req;
  logic [1:0]  o_skin_sel;
  logic        o_skin_we;
  logic [15:0] o_unit_ien;
  logic [15:0] o_unit_oen;
  logic        o_busy;
  logic        o_halted;
  logic        o_timeout;
  logic [38:0] dut_out;

  unit_controller #(.DATA_WIDTH(16), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_skin_ack(i_skin_ack),
    .i_instruction(i_instruction), .o_skin_req(o_skin_req), .o_skin_sel(o_skin_sel),
    .o_skin_we(o_skin_we), .o_unit_ien(o_unit_ien), .o_unit_oen(o_unit_oen),
    .o_busy(o_busy), .o_halted(o_halted), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  assign dut_out = {o_skin_req, o_skin_sel, o_skin_we, o_unit_ien, o_unit_oen,
                    o_busy, o_halted, o_timeout};

  // am/sm: 0 = drive low, 1 = drive high, 2 = random (DUT must ignore it)
  typedef struct {
    logic [38:0] o;
    logic [15:0] ir;
    int          am;
    int          sm;
  } ent_t;

  ent_t q[$];
  ent_t e;
  bit   exp_halted;
  bit   exp_timeout;
  int   checks;
  int   failures;

  function automatic logic [38:0] pk(bit req, int sel, bit we, logic [15:0] ien,
                                     logic [15:0] oen, bit busy, bit halted);
    return {req, 2'(sel), we, ien, oen, busy, halted, exp_timeout};
  endfunction

  task automatic push(logic [38:0] o, logic [7:0] ir, int am, int sm);
    ent_t n;
    n.o  = o;
    n.ir = {8'($urandom), ir};
    n.am = am;
    n.sm = sm;
    q.push_back(n);
  endtask

  task automatic model_start();
    push(pk(0, 0, 0, '0, '0, 0, exp_halted), 8'($urandom), 2, 1);
    exp_timeout = 0;
    exp_halted  = 0;
  endtask

  // f/s: cycles the fetch/skin request stays up before ack; 0 = never acked
  task automatic model_instr(logic [7:0] ir, int f, int s);
    int dst = int'(ir[7:4]);
    int src = int'(ir[3:0]);
    logic [15:0] d1 = 16'h1 << dst;
    logic [15:0] s1 = 16'h1 << src;
    bit s_sk = (src >= 11 && src <= 13);
    bit d_sk = (dst >= 11 && dst <= 13);
    int n;
    n = (f == 0) ? TO : f;
    for (int i = 0; i < n; i++) push(pk(1, 0, 0, '0, '0, 1, 0), ir, (f != 0 && i == f - 1) ? 1 : 0, 2);
    if (f == 0) begin
      exp_timeout = 1; exp_halted = 1;
      push(pk(0, 0, 0, '0, '0, 0, 1), ir, 2, 0);
      return;
    end
    push(pk(0, 0, 0, 16'h0001, 16'h0800, 1, 0), ir, 2, 2);
    push(pk(0, 0, 0, '0, '0, 1, 0), ir, 2, 2);
    if (dst == 15 && src == 15) begin
      exp_halted = 1;
      push(pk(0, 0, 0, '0, '0, 0, 1), ir, 2, 0);
    end else if (src >= 14 || dst >= 14 || (s_sk && d_sk)) begin
      push(pk(0, 0, 0, '0, '0, 1, 0), ir, 2, 2);
    end else if (s_sk || d_sk) begin
      n = (s == 0) ? TO : s;
      for (int i = 0; i < n; i++)
        push(pk(1, s_sk ? src - 11 : dst - 11, d_sk, '0, d_sk ? s1 : '0, 1, 0), ir,
             (s != 0 && i == s - 1) ? 1 : 0, 2);
      if (s == 0) begin
        exp_timeout = 1; exp_halted = 1;
        push(pk(0, 0, 0, '0, '0, 0, 1), ir, 2, 0);
      end else if (s_sk) push(pk(0, 0, 0, d1, s1, 1, 0), ir, 2, 2);
      else               push(pk(0, 0, 0, '0, '0, 1, 0), ir, 2, 2);
    end else begin
      push(pk(0, 0, 0, d1, s1, 1, 0), ir, 2, 2);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst_n = 1;
      i_skin_ack = 1'($urandom_range(0, 1));
      i_start = 0;
      @(posedge clk); #1;
      checks++;
      if (dut_out !== pk(0, 0, 0, '0, '0, 0, 0)) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", c, dut_out, pk(0, 0, 0, '0, '0, 0, 0));
      end
    end
  endtask

  task automatic test_move();
    int c = 0;
    model_start();
    model_instr(8'h43, 2, 1);
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL move cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_skin_read();
    int c = 0, pulses = 0;
    bit prev = 0, dbl = 0;
    model_start();
    model_instr(8'h3B, 3, 3);
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL skin_read cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      if (o_unit_oen[11] === 1'b1) begin
        pulses++;
        if (prev) dbl = 1;
      end
      prev = (o_unit_oen[11] === 1'b1);
      c++;
      @(posedge clk); #1;
    end
    // two pulses for the immediate read plus the HALT instruction's fetch
    checks++;
    if (pulses != 3 || dbl) begin
      failures++;
      $display("FAIL oen11_pulses got=%0d held=%0d exp=3 held=0", pulses, dbl);
    end
  endtask

  task automatic test_skin_write();
    int c = 0;
    model_start();
    model_instr(8'hC3, 2, 3);
    model_instr(8'hD4, 1, 1);
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL skin_write cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_nop();
    int c = 0;
    model_start();
    model_instr(8'hEB, 1, 1);
    model_instr(8'hBC, 1, 1);
    model_instr(8'hF3, 1, 1);
    model_instr(8'hFF, 2, 1);
    model_start();
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL halt_nop cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    model_start();
    model_instr(8'h12, 0, 1);
    model_start();
    model_instr(8'hC5, 1, 0);
    model_start();
    model_instr(8'hB4, TO, TO);
    model_instr(8'h3D, 1, TO);
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int c = 0;
    model_start();
    for (int k = 0; k < 60; k++) begin
      logic [7:0] ir = 8'($urandom);
      int f = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TO));
      int s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      model_instr(ir, f, s);
      if (exp_halted) model_start();
    end
    model_instr(8'hFF, 1, 1);
    while (q.size() != 0) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL random cyc=%0d ir=%h got=%h exp=%h", c, e.ir[7:0], dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    model_start();
    model_instr(8'h3B, 1, TO);
    while (q.size() > 5) begin
      e = q.pop_front();
      i_instruction = e.ir;
      i_skin_ack = (e.am == 2) ? 1'($urandom_range(0, 1)) : (e.am == 1);
      i_start    = (e.sm == 2) ? 1'($urandom_range(0, 1)) : (e.sm == 1);
      checks++;
      if (dut_out !== e.o) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, dut_out, e.o);
      end
      c++;
      @(posedge clk); #1;
    end
    e = q.pop_front();
    q.delete();
    checks++;
    if (dut_out !== e.o) begin
      failures++;
      $display("FAIL reset_mid_rd got=%h exp=%h", dut_out, e.o);
    end
    rst_n = 0; i_skin_ack = 0; i_start = 0;
    @(posedge clk); #1;
    rst_n = 1;
    exp_halted = 0; exp_timeout = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_out !== pk(0, 0, 0, '0, '0, 0, 0)) begin
        failures++;
        $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", k, dut_out, pk(0, 0, 0, '0, '0, 0, 0));
      end
      i_skin_ack = 1;
      @(posedge clk); #1;
    end
    i_skin_ack = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_halted = 0; exp_timeout = 0;
    rst_n = 0; i_start = 0; i_skin_ack = 0; i_instruction = '0;
    @(posedge clk); #1;
    test_reset();
    test_move();
    test_skin_read();
    test_skin_write();
    test_halt_nop();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
